frame_max_buffer: RTL and testbench

- Sits directly upstream of the normalisation stage.
- Captures one cropped frame from the crop filter's pixel stream into on-chip memory and tracks the frame's maximum pixel value.
- Then presents that maximum as the normalisation denominator, signals completion, and replays the buffered frame to the normaliser.
- Converts the streaming crop output into the "frame complete, denominator known, now read" contract the normaliser requires.

---
 rtl/frame_buf_pkg.sv | 19 +
 rtl/sdp_ram.sv | 35 +++
 rtl/frame_max_buffer.sv | 213 +++++++++++++++++++++
 tb/tb_frame_max_buffer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_buf_pkg.sv
// Shared types and helpers for the frame maximum buffer.
package frame_buf_pkg;

  // Top-level controller states: wait for start, fill the buffer, replay it.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  // Position of the start-of-frame flag inside tuser.
  localparam int SOF_BIT = 0;

  // The normaliser divides by this value, so a black frame must not produce 0.
  function automatic logic [31:0] sat_denom(input logic [31:0] max_val);
    return (max_val == 32'd0) ? 32'd1 : max_val;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
// Reads and writes never target the same address in the same cycle, because
// the buffer is only written while capturing and only read while draining.
module sdp_ram #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: store the incoming pixel when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: rd_data only changes when a read is requested, so it can be
  // held by simply withholding re while the consumer is stalled.
  always_ff @(posedge clk) begin
    if (re) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/frame_max_buffer.sv
// Captures one cropped frame, tracks its maximum pixel, publishes that maximum
// as the normalisation denominator and then replays the stored frame.
module frame_max_buffer
  import frame_buf_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = 10,
  parameter int USER_WIDTH      = 2,
  parameter int DEPTH           = 1024,
  parameter int ADDR_W          = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       ap_start,
  output logic                       ap_done,
  output logic                       ap_idle,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [PIXEL_BIT_WIDTH-1:0] s_axis_tdata,
  input  logic [USER_WIDTH-1:0]      s_axis_tuser,
  input  logic                       s_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [PIXEL_BIT_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tlast,
  output logic [PIXEL_BIT_WIDTH-1:0] norm_denominator,
  output logic [ADDR_W:0]            pixel_count,
  output logic                       overflow
);

  localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  state_t state, state_next;

  // Capture-side state.
  logic [ADDR_W:0]            count;
  logic [PIXEL_BIT_WIDTH-1:0] running_max;

  // Drain-side state: read pointer, RAM output stage and output register.
  logic [ADDR_W:0]            rd_ptr;
  logic                       stage1_valid;
  logic                       stage1_last;
  logic                       out_valid;
  logic                       out_last;
  logic [PIXEL_BIT_WIDTH-1:0] out_data;
  logic [PIXEL_BIT_WIDTH-1:0] ram_rd_data;

  // Combinational helpers.
  logic                       beat;
  logic                       sof;
  logic                       restart;
  logic                       hit_depth;
  logic                       frame_end;
  logic [ADDR_W:0]            count_next;
  logic [PIXEL_BIT_WIDTH-1:0] max_next;
  logic [ADDR_W-1:0]          wr_addr;
  logic                       rd_en;
  logic                       out_load;
  logic                       out_fire;
  logic                       drain_done;
  logic                       user_unused;

  // Only the start-of-frame bit of tuser carries meaning here.
  assign user_unused = ^s_axis_tuser;

  // Per-beat capture arithmetic: where the pixel lands, the new count and the
  // new running maximum. A start-of-frame beat, or the very first beat after
  // ap_start, restarts the frame so the maximum is loaded rather than compared.
  always_comb begin
    beat       = (state == CAPTURE) && s_axis_tvalid;
    sof        = s_axis_tuser[SOF_BIT];
    restart    = sof || (count == '0);
    wr_addr    = sof ? '0 : count[ADDR_W-1:0];
    count_next = sof ? ONE : (count + ONE);
    if (restart) begin
      max_next = s_axis_tdata;
    end else if (s_axis_tdata > running_max) begin
      max_next = s_axis_tdata;
    end else begin
      max_next = running_max;
    end
    hit_depth  = (count_next == DEPTH_CNT);
    frame_end  = beat && (s_axis_tlast || hit_depth);
  end

  // Replay pipeline control: the output register loads whenever it is empty or
  // being consumed, and the RAM is read ahead whenever its output stage is
  // empty or moving into the output register. Gating the read keeps the RAM
  // output stable, so the two stages together act as a two-entry buffer that
  // sustains one beat per cycle under arbitrary backpressure.
  always_comb begin
    out_fire   = out_valid && m_axis_tready;
    out_load   = stage1_valid && (!out_valid || m_axis_tready);
    rd_en      = (state == DRAIN) && (rd_ptr < count) && (!stage1_valid || out_load);
    drain_done = out_fire && out_last;
  end

  // Next-state logic and the state-derived handshake outputs.
  always_comb begin
    state_next    = state;
    ap_idle       = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    unique case (state)
      IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        s_axis_tready = 1'b1;
        if (frame_end) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        m_axis_tvalid = out_valid;
        if (drain_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (srst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture bookkeeping: count, running maximum, overflow flag, completion
  // pulse and the published denominator, which only changes on completion.
  always_ff @(posedge clk) begin
    if (srst) begin
      count            <= '0;
      running_max      <= '0;
      overflow         <= 1'b0;
      ap_done          <= 1'b0;
      norm_denominator <= PIXEL_BIT_WIDTH'(1);
    end else begin
      ap_done <= 1'b0;
      if ((state == IDLE) && ap_start) begin
        count       <= '0;
        running_max <= '0;
        overflow    <= 1'b0;
      end else if (beat) begin
        count       <= count_next;
        running_max <= max_next;
        if (frame_end) begin
          ap_done          <= 1'b1;
          norm_denominator <= PIXEL_BIT_WIDTH'(sat_denom(32'(max_next)));
          if (!s_axis_tlast && hit_depth) begin
            overflow <= 1'b1;
          end
        end
      end
    end
  end

  // Replay datapath: advance the read pointer, track which fetched word is the
  // last one, and move words from the RAM stage into the output register.
  always_ff @(posedge clk) begin
    if (srst || (state != DRAIN)) begin
      rd_ptr       <= '0;
      stage1_valid <= 1'b0;
      stage1_last  <= 1'b0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_data     <= '0;
    end else begin
      if (rd_en) begin
        rd_ptr       <= rd_ptr + ONE;
        stage1_last  <= (rd_ptr == (count - ONE));
        stage1_valid <= 1'b1;
      end else if (out_load) begin
        stage1_valid <= 1'b0;
      end
      if (out_load) begin
        out_valid <= 1'b1;
        out_data  <= ram_rd_data;
        out_last  <= stage1_last;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign m_axis_tdata = out_data;
  assign m_axis_tlast = out_last;
  assign pixel_count  = count;

  sdp_ram #(
    .DATA_W (PIXEL_BIT_WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we      (beat),
    .wr_addr (wr_addr),
    .wr_data (s_axis_tdata),
    .re      (rd_en),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (ram_rd_data)
  );

endmodule

// File: tb/tb_frame_max_buffer.sv
// Self-checking bench for frame_max_buffer, using a small buffer depth so the
// overflow path is reachable, directed frames plus randomized frames, and a
// queue-based reference model of what a captured frame should contain.
module tb_frame_max_buffer;

  localparam int PW    = 10;
  localparam int UW    = 2;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          srst;
  logic          ap_start;
  logic          ap_done;
  logic          ap_idle;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [PW-1:0] s_axis_tdata;
  logic [UW-1:0] s_axis_tuser;
  logic          s_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [PW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic [PW-1:0] norm_denominator;
  logic [AW:0]   pixel_count;
  logic          overflow;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: the pixels the frame should hold, overflow and denominator.
  logic [PW-1:0] model_q [$];
  bit            model_ovf;
  int            model_denom = 1;

  // Beats to offer for the next frame.
  logic [PW-1:0] beat_data [$];
  bit            beat_sof  [$];
  bit            beat_last [$];
  int            gap_max = 0;

  frame_max_buffer #(
    .PIXEL_BIT_WIDTH (PW),
    .USER_WIDTH      (UW),
    .DEPTH           (DEPTH)
  ) dut (
    .clk              (clk),
    .srst             (srst),
    .ap_start         (ap_start),
    .ap_done          (ap_done),
    .ap_idle          (ap_idle),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tuser     (s_axis_tuser),
    .s_axis_tlast     (s_axis_tlast),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tlast     (m_axis_tlast),
    .norm_denominator (norm_denominator),
    .pixel_count      (pixel_count),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic addBeat(input int d, input bit sof, input bit last);
    beat_data.push_back(PW'(d));
    beat_sof.push_back(sof);
    beat_last.push_back(last);
  endtask

  task automatic clearBeats();
    beat_data.delete();
    beat_sof.delete();
    beat_last.delete();
  endtask

  // Pulse ap_start, offer the queued beats and check the completion cycle.
  // Returns how many beats were left over after the frame closed.
  task automatic applyStimulus(output int extras);
    bit done;
    int mx;
    @(negedge clk);
    ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
    checkOutput("idle_in_capture", 32'(ap_idle), 32'd0);
    checkOutput("count_cleared", 32'(pixel_count), 32'd0);
    checkOutput("denom_retained", 32'(norm_denominator), 32'(model_denom));
    checkOutput("ovf_cleared", 32'(overflow), 32'd0);
    model_q.delete();
    model_ovf = 1'b0;
    done      = 1'b0;
    extras    = 0;
    for (int i = 0; i < beat_data.size(); i++) begin
      if (done) begin
        extras++;
        continue;
      end
      repeat ($urandom_range(0, gap_max)) begin
        s_axis_tvalid = 1'b0;
        @(negedge clk);
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = beat_data[i];
      s_axis_tuser  = {1'b0, beat_sof[i]};
      s_axis_tlast  = beat_last[i];
      checkOutput("s_tready_capture", 32'(s_axis_tready), 32'd1);
      if (beat_sof[i]) model_q.delete();
      model_q.push_back(beat_data[i]);
      if (beat_last[i]) begin
        done = 1'b1;
      end else if (model_q.size() == DEPTH) begin
        done      = 1'b1;
        model_ovf = 1'b1;
      end
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = '0;
    mx = 0;
    foreach (model_q[k]) if (int'(model_q[k]) > mx) mx = int'(model_q[k]);
    model_denom = (mx == 0) ? 1 : mx;
    checkOutput("ap_done", 32'(ap_done), 32'd1);
    checkOutput("denominator", 32'(norm_denominator), 32'(model_denom));
    checkOutput("pixel_count", 32'(pixel_count), 32'(model_q.size()));
    checkOutput("overflow", 32'(overflow), 32'(model_ovf));
  endtask

  // Drain the frame under the chosen ready pattern and compare every beat
  // against the model. Starts on the cycle where ap_done is high.
  task automatic drainFrame(input int extras, input int ready_mode, input int abort_after);
    int            idx        = 0;
    int            cycle      = 0;
    int            first_seen = -1;
    bit            stalled    = 1'b0;
    bit            finished   = 1'b0;
    bit            aborted    = 1'b0;
    bit            rdy;
    logic [PW-1:0] held_d;
    logic          held_l;
    bit            pattern [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    while (!finished && cycle < 200) begin
      if (cycle == 1) checkOutput("ap_done_width", 32'(ap_done), 32'd0);
      if (cycle < extras) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = PW'($urandom_range(0, 1023));
        checkOutput("s_tready_drain", 32'(s_axis_tready), 32'd0);
      end else begin
        s_axis_tvalid = 1'b0;
      end
      ap_start = (cycle == 3);
      if (stalled) begin
        checkOutput("hold_valid", 32'(m_axis_tvalid), 32'd1);
        checkOutput("hold_data", 32'(m_axis_tdata), 32'(held_d));
        checkOutput("hold_last", 32'(m_axis_tlast), 32'(held_l));
      end
      if (m_axis_tvalid && first_seen < 0) begin
        first_seen = cycle;
        checkOutput("first_valid_latency", 32'(cycle), 32'd2);
      end
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        2:       rdy = (first_seen < 0) ? 1'b0 : pattern[(cycle - first_seen) % 6];
        default: rdy = ((cycle % 2) == 1);
      endcase
      m_axis_tready = rdy;
      if (m_axis_tvalid && rdy) begin
        if (idx < model_q.size()) begin
          checkOutput("replay_data", 32'(m_axis_tdata), 32'(model_q[idx]));
          checkOutput("replay_last", 32'(m_axis_tlast), 32'(idx == model_q.size() - 1));
        end else begin
          checkOutput("replay_excess", 32'(idx), 32'(model_q.size() - 1));
        end
        idx++;
        stalled = 1'b0;
        if (m_axis_tlast) finished = 1'b1;
        if (abort_after > 0 && idx == abort_after) begin
          aborted = 1'b1;
          break;
        end
      end else if (m_axis_tvalid) begin
        stalled = 1'b1;
        held_d  = m_axis_tdata;
        held_l  = m_axis_tlast;
      end else begin
        stalled = 1'b0;
      end
      @(negedge clk);
      cycle++;
    end
    ap_start      = 1'b0;
    s_axis_tvalid = 1'b0;
    if (!aborted) begin
      m_axis_tready = 1'b0;
      checkOutput("drain_finished", 32'(finished), 32'd1);
      checkOutput("replay_count", 32'(idx), 32'(model_q.size()));
      checkOutput("idle_after", 32'(ap_idle), 32'd1);
      checkOutput("m_tvalid_after", 32'(m_axis_tvalid), 32'd0);
      checkOutput("count_held", 32'(pixel_count), 32'(model_q.size()));
      checkOutput("denom_held", 32'(norm_denominator), 32'(model_denom));
    end
  endtask

  task automatic runFrame(input int ready_mode);
    int extras;
    applyStimulus(extras);
    drainFrame((extras > 3) ? 3 : extras, ready_mode, 0);
  endtask

  initial begin
    int extras;
    srst          = 1'b1;
    ap_start      = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_idle", 32'(ap_idle), 32'd1);
    checkOutput("rst_done", 32'(ap_done), 32'd0);
    checkOutput("rst_denom", 32'(norm_denominator), 32'd1);
    checkOutput("rst_s_tready", 32'(s_axis_tready), 32'd0);
    checkOutput("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    checkOutput("rst_count", 32'(pixel_count), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    srst = 1'b0;

    // Basic 4-pixel frame.
    $display("[TB] frame {5,17,3,9}");
    clearBeats();
    addBeat(5, 1, 0); addBeat(17, 0, 0); addBeat(3, 0, 0); addBeat(9, 0, 1);
    runFrame(0);

    // Black frame saturates the denominator to 1.
    $display("[TB] all-zero frame");
    clearBeats();
    addBeat(0, 1, 0); addBeat(0, 0, 0); addBeat(0, 0, 1);
    runFrame(0);

    // Ten beats without tlast against an 8-deep buffer.
    $display("[TB] overflow frame");
    clearBeats();
    for (int i = 0; i < 10; i++) addBeat(100 + i, (i == 0), 0);
    runFrame(0);

    // tlast exactly on the DEPTH-th beat is not an overflow.
    $display("[TB] tlast on last buffer slot");
    clearBeats();
    for (int i = 0; i < DEPTH; i++) addBeat(50 - i, (i == 0), (i == DEPTH - 1));
    runFrame(3);

    // Stalled replay with a fixed ready pattern.
    $display("[TB] frame {1023,2,4} with stalls");
    clearBeats();
    addBeat(1023, 1, 0); addBeat(2, 0, 0); addBeat(4, 0, 1);
    runFrame(2);

    // Start-of-frame in the middle restarts the capture.
    $display("[TB] mid-capture SOF");
    clearBeats();
    addBeat(7, 1, 0); addBeat(8, 0, 0); addBeat(2, 1, 0); addBeat(3, 0, 1);
    runFrame(0);

    // Single-pixel frame.
    $display("[TB] one-pixel frame");
    clearBeats();
    addBeat(42, 1, 1);
    runFrame(3);

    // Reset in the middle of a replay abandons the frame.
    $display("[TB] reset during drain");
    clearBeats();
    addBeat(10, 1, 0); addBeat(20, 0, 0); addBeat(30, 0, 1);
    applyStimulus(extras);
    drainFrame(0, 0, 1);
    srst = 1'b1;
    @(negedge clk);
    srst          = 1'b0;
    m_axis_tready = 1'b0;
    model_denom   = 1;
    checkOutput("srst_idle", 32'(ap_idle), 32'd1);
    checkOutput("srst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    checkOutput("srst_denom", 32'(norm_denominator), 32'd1);
    checkOutput("srst_overflow", 32'(overflow), 32'd0);
    clearBeats();
    addBeat(6, 1, 1);
    runFrame(0);

    // Randomized frames with gaps, mid-frame restarts and random backpressure.
    $display("[TB] random frames");
    gap_max = 1;
    for (int f = 0; f < 30; f++) begin
      int len;
      bit sof;
      bit last;
      int d;
      len = $urandom_range(1, 10);
      clearBeats();
      for (int i = 0; i < len; i++) begin
        sof  = (i == 0) || (len <= DEPTH && $urandom_range(0, 5) == 0);
        last = (i == len - 1) && (len <= DEPTH || $urandom_range(0, 1) == 1);
        d    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 1023);
        addBeat(d, sof, last);
      end
      runFrame($urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
